// File: rtl/ldpc_dec_pkg.sv
// Shared defaults and FSM encoding for the layered LDPC
// decoder read-side scheduler.
package ldpc_dec_pkg;

  localparam int DEF_LAYERS    = 2;
  localparam int DEF_ADDRWIDTH = 5;
  localparam int DEF_ADDRDEPTH = 20;
  localparam int DEF_ITERBITS  = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/raw_scoreboard.sv
// Per-address pending bits guarding LLR read-after-write.
// A set and a clear on the same address in one cycle leaves it set.
module raw_scoreboard #(
  parameter int DEPTH = 20,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_en,
  input  logic [AW-1:0] set_idx,
  input  logic          set_layer,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_idx,
  input  logic          clr_layer,
  input  logic [AW-1:0] lk_idx,
  output logic          lk_hit,
  output logic          all_clear
);

  localparam logic [DEPTH-1:0] ONE = {{(DEPTH-1){1'b0}}, 1'b1};

  logic [DEPTH-1:0] pend_q, pend_d;
  logic [DEPTH-1:0] lay_q, lay_d;
  logic [DEPTH-1:0] set_m, clr_m, lk_m;

  // One-hot masks; out-of-range indices select nothing.
  always_comb begin
    set_m = '0;
    clr_m = '0;
    lk_m  = '0;
    if (set_en && (32'(set_idx) < DEPTH))
      set_m = ONE << set_idx;
    if (clr_en && (32'(clr_idx) < DEPTH))
      clr_m = ONE << clr_idx;
    if (32'(lk_idx) < DEPTH)
      lk_m = ONE << lk_idx;
    pend_d = (pend_q & ~clr_m) | set_m;
    lay_d  = (lay_q & ~set_m) | (set_layer ? set_m : '0);
  end

  // Pending vector and the layer each pending read came from.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= '0;
      lay_q  <= '0;
    end else begin
      pend_q <= pend_d;
      lay_q  <= lay_d;
    end
  end

  assign lk_hit    = |(pend_q & lk_m);
  assign all_clear = (pend_q == '0);

  // A write-back retiring a pending read must carry its layer.
  wb_layer_a : assert property (
    @(posedge clk) disable iff (!rst)
    (|(pend_q & clr_m)) |-> (clr_layer == (|(lay_q & clr_m)))
  );

endmodule

// File: rtl/layer_read_sched.sv
// Read-side row scheduler for the layered LDPC SISO row unit.
// Optional EARLY_TERM_EN: drain per iteration and stop on parity_ok.
module layer_read_sched
  import ldpc_dec_pkg::*;
#(
  parameter int LAYERS    = DEF_LAYERS,
  parameter int ADDRWIDTH = DEF_ADDRWIDTH,
  parameter int ADDRDEPTH = DEF_ADDRDEPTH,
  parameter int ITERBITS  = DEF_ITERBITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ITERBITS-1:0]  max_iter,
  input  logic                 wren,
  input  logic                 wrlayer,
  input  logic [ADDRWIDTH-1:0] wraddress,
`ifdef EARLY_TERM_EN
  input  logic                 parity_ok,
`endif
  output logic                 rdlayer,
  output logic [ADDRWIDTH-1:0] rdaddress,
  output logic                 rden_LLR,
  output logic                 rden_E,
  output logic [ITERBITS-1:0]  iter_count,
  output logic                 busy,
  output logic                 done
);

  localparam logic [ADDRWIDTH-1:0] ADDR_ONE  = {{(ADDRWIDTH-1){1'b0}}, 1'b1};
  localparam logic [ITERBITS-1:0]  ITER_ONE  = {{(ITERBITS-1){1'b0}}, 1'b1};
  localparam logic [ADDRWIDTH-1:0] ADDR_LAST = ADDRWIDTH'(ADDRDEPTH - 1);
  localparam logic                 LAY_LAST  = 1'(LAYERS - 1);

  state_e                 state_q, state_d;
  logic                   layer_q, layer_d;
  logic [ADDRWIDTH-1:0]   addr_q, addr_d;
  logic [ITERBITS-1:0]    iter_q, iter_d;
  logic [ITERBITS-1:0]    max_q, max_d;
  logic                   rdlayer_q, rdlayer_d;
  logic [ADDRWIDTH-1:0]   rdaddr_q, rdaddr_d;
  logic                   rden_llr_q, rden_llr_d;
  logic                   rden_e_q, rden_e_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   issue;
  logic                   lk_hit;
  logic                   all_clear;
  logic [ITERBITS-1:0]    iter_inc;

  assign iter_inc = iter_q + ITER_ONE;

  raw_scoreboard #(
    .DEPTH (ADDRDEPTH),
    .AW    (ADDRWIDTH)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .set_en    (issue),
    .set_idx   (addr_q),
    .set_layer (layer_q),
    .clr_en    (wren),
    .clr_idx   (wraddress),
    .clr_layer (wrlayer),
    .lk_idx    (addr_q),
    .lk_hit    (lk_hit),
    .all_clear (all_clear)
  );

  // Next-state, sequencing and output decode.
  always_comb begin
    state_d    = state_q;
    layer_d    = layer_q;
    addr_d     = addr_q;
    iter_d     = iter_q;
    max_d      = max_q;
    rdlayer_d  = rdlayer_q;
    rdaddr_d   = rdaddr_q;
    rden_llr_d = 1'b0;
    rden_e_d   = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    issue      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          max_d   = max_iter;
          layer_d = 1'b0;
          addr_d  = '0;
          iter_d  = '0;
          if (max_iter != '0) begin
            state_d = S_RUN;
            busy_d  = 1'b1;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      S_RUN: begin
        if (!lk_hit) begin
          issue      = 1'b1;
          rden_llr_d = 1'b1;
          rden_e_d   = (iter_q != '0);
          rdlayer_d  = layer_q;
          rdaddr_d   = addr_q;
          if (addr_q == ADDR_LAST) begin
            addr_d = '0;
            if (layer_q == LAY_LAST) begin
              layer_d = 1'b0;
              iter_d  = iter_inc;
`ifdef EARLY_TERM_EN
              state_d = S_DRAIN;
`else
              if (iter_inc == max_q)
                state_d = S_DRAIN;
`endif
            end else begin
              layer_d = layer_q + 1'b1;
            end
          end else begin
            addr_d = addr_q + ADDR_ONE;
          end
        end
      end
      S_DRAIN: begin
        if (all_clear) begin
`ifdef EARLY_TERM_EN
          if (parity_ok || (iter_q == max_q)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = S_RUN;
          end
`else
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      layer_q    <= 1'b0;
      addr_q     <= '0;
      iter_q     <= '0;
      max_q      <= '0;
      rdlayer_q  <= 1'b0;
      rdaddr_q   <= '0;
      rden_llr_q <= 1'b0;
      rden_e_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      layer_q    <= layer_d;
      addr_q     <= addr_d;
      iter_q     <= iter_d;
      max_q      <= max_d;
      rdlayer_q  <= rdlayer_d;
      rdaddr_q   <= rdaddr_d;
      rden_llr_q <= rden_llr_d;
      rden_e_q   <= rden_e_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign rdlayer    = rdlayer_q;
  assign rdaddress  = rdaddr_q;
  assign rden_LLR   = rden_llr_q;
  assign rden_E     = rden_e_q;
  assign iter_count = iter_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_layer_read_sched.sv
// Scoreboard bench for layer_read_sched: random write-back latency,
// spurious write-backs, restart-while-busy and mid-decode reset.
module tb_layer_read_sched;

  localparam int LAYERS = 2;
  localparam int AW     = 5;
  localparam int DEPTH  = 20;
  localparam int IB     = 5;

  typedef struct packed {
    logic          l;
    logic [AW-1:0] a;
    logic          e;
  } rd_t;

  typedef struct packed {
    logic [31:0]   due;
    logic          l;
    logic [AW-1:0] a;
  } wb_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [IB-1:0] max_iter = '0;
  logic          wren = 1'b0;
  logic          wrlayer = 1'b0;
  logic [AW-1:0] wraddress = '0;
  logic          rdlayer;
  logic [AW-1:0] rdaddress;
  logic          rden_LLR;
  logic          rden_E;
  logic [IB-1:0] iter_count;
  logic          busy;
  logic          done;
`ifdef EARLY_TERM_EN
  logic          parity_ok;
  int            pk_iter = 0;
`endif

  rd_t           exp_q[$];
  logic [IB-1:0] exp_done_q[$];
  wb_t           wb_q[$];
  bit            outstanding [DEPTH];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int lat_min = 14;
  int lat_max = 14;
  bit spur_en = 1'b0;
  bit hold = 1'b0;
  bit seen_l1a7 = 1'b0;
  int reads_seen = 0;
  int first_rd = -1;
  int last_rd = -1;

  always #5 clk = ~clk;

`ifdef EARLY_TERM_EN
  assign parity_ok = (pk_iter != 0) &&
                     (reads_seen >= pk_iter * LAYERS * DEPTH);
`endif

  layer_read_sched #(
    .LAYERS    (LAYERS),
    .ADDRWIDTH (AW),
    .ADDRDEPTH (DEPTH),
    .ITERBITS  (IB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .max_iter   (max_iter),
    .wren       (wren),
    .wrlayer    (wrlayer),
    .wraddress  (wraddress),
`ifdef EARLY_TERM_EN
    .parity_ok  (parity_ok),
`endif
    .rdlayer    (rdlayer),
    .rdaddress  (rdaddress),
    .rden_LLR   (rden_LLR),
    .rden_E     (rden_E),
    .iter_count (iter_count),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  function automatic int n_out();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += outstanding[i] ? 1 : 0;
    return n;
  endfunction

  task automatic flush();
    exp_q.delete();
    exp_done_q.delete();
    wb_q.delete();
    for (int i = 0; i < DEPTH; i++) outstanding[i] = 1'b0;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Write-back model: retire each read after its drawn latency.
  always @(posedge clk) begin
    wb_t w;
    int  r;
    #1;
    if (hold) begin
      wren = 1'b0;
    end else if (wb_q.size() > 0 && int'(wb_q[0].due) <= cyc) begin
      w = wb_q.pop_front();
      wren = 1'b1;
      wrlayer = w.l;
      wraddress = w.a;
      outstanding[int'(w.a)] = 1'b0;
    end else if (spur_en && $urandom_range(3) == 0) begin
      r = int'($urandom_range(31));
      if ((r < DEPTH && outstanding[r]) ||
          (rden_LLR && int'(rdaddress) == r)) begin
        wren = 1'b0;
      end else begin
        wren = 1'b1;
        wrlayer = 1'($urandom_range(1));
        wraddress = AW'(r);
      end
    end else begin
      wren = 1'b0;
    end
  end

  // Monitor: compare each read and done pulse against the model.
  always @(negedge clk) begin
    rd_t x;
    int  due;
    if (!hold) begin
      if (rden_LLR) begin
        reads_seen++;
        if (exp_q.size() == 0) begin
          chk("unexpected_read", 32'(rdaddress), 32'hffff);
        end else begin
          x = exp_q.pop_front();
          chk("rd_layer", 32'(rdlayer), 32'(x.l));
          chk("rd_addr", 32'(rdaddress), 32'(x.a));
          chk("rd_E", 32'(rden_E), 32'(x.e));
        end
        chk("busy_on_read", 32'(busy), 1);
        if (int'(rdaddress) < DEPTH) begin
          chk("raw_hazard", 32'(outstanding[int'(rdaddress)]), 0);
          outstanding[int'(rdaddress)] = 1'b1;
          due = cyc + int'($urandom_range(lat_max, lat_min));
          if (wb_q.size() > 0 && due <= int'(wb_q[$].due))
            due = int'(wb_q[$].due) + 1;
          wb_q.push_back('{due: 32'(due), l: rdlayer, a: rdaddress});
        end
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
        if (rdlayer == 1'b1 && rdaddress == AW'(7)) seen_l1a7 = 1'b1;
      end else if (rden_E) begin
        chk("rdE_without_LLR", 32'(rden_E), 0);
      end
      if (done) begin
        if (exp_done_q.size() == 0) begin
          chk("unexpected_done", 32'(done), 0);
        end else begin
          chk("done_iter", 32'(iter_count), 32'(exp_done_q.pop_front()));
          chk("done_reads_left", 32'(exp_q.size()), 0);
          chk("done_wb_left", 32'(n_out()), 0);
          chk("done_busy", 32'(busy), 0);
        end
      end
    end
  end

  task automatic decode(input int mi, input int lmin, input int lmax,
                        input bit spur, input bit restart,
                        input bit nostall);
    int it;
    int k;
    lat_min = lmin;
    lat_max = lmax;
    spur_en = spur;
    it = mi;
`ifdef EARLY_TERM_EN
    if (pk_iter > 0 && pk_iter < mi) it = pk_iter;
`endif
    for (int i = 0; i < it; i++)
      for (int l = 0; l < LAYERS; l++)
        for (int a = 0; a < DEPTH; a++)
          exp_q.push_back('{l: 1'(l), a: AW'(a), e: (i != 0)});
    exp_done_q.push_back(IB'(it));
    reads_seen = 0;
    first_rd = -1;
    @(posedge clk); #1;
    start = 1'b1;
    max_iter = IB'(mi);
    @(posedge clk); #1;
    start = 1'b0;
    max_iter = IB'($urandom);
    if (restart) begin
      repeat (30) @(posedge clk);
      #1;
      start = 1'b1;
      max_iter = IB'(7);
      @(posedge clk); #1;
      start = 1'b0;
    end
    k = 0;
    while (k < 8000 && exp_done_q.size() != 0) begin
      @(posedge clk);
      k++;
    end
    if (exp_done_q.size() != 0) begin
      chk("done_timeout", 32'(k), 0);
      flush();
    end
`ifndef EARLY_TERM_EN
    if (nostall)
      chk("nostall_span", 32'(last_rd - first_rd), 32'(it * LAYERS * DEPTH - 1));
`endif
    repeat (3) @(posedge clk);
    spur_en = 1'b0;
  endtask

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rden_LLR", 32'(rden_LLR), 0);
    chk("rst_rden_E", 32'(rden_E), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_iter", 32'(iter_count), 0);
    chk("rst_rdaddr", 32'(rdaddress), 0);
    chk("rst_rdlayer", 32'(rdlayer), 0);
    rst = 1'b1;

    decode(2, 14, 14, 1'b0, 1'b0, 1'b1);
    decode(1, 30, 30, 1'b0, 1'b0, 1'b0);
    for (int t = 0; t < 4; t++)
      decode(int'($urandom_range(3, 1)), 10, 40, 1'b1, 1'b0, 1'b0);
    decode(3, 12, 25, 1'b1, 1'b1, 1'b0);

    // Zero iterations: done right after start, no reads.
    exp_done_q.push_back('0);
    @(posedge clk); #1;
    start = 1'b1;
    max_iter = '0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("zero_done", 32'(done), 1);
    chk("zero_busy", 32'(busy), 0);
    repeat (4) @(posedge clk);
    chk("zero_done_popped", 32'(exp_done_q.size()), 0);

    // Asynchronous reset in the middle of layer 1.
    seen_l1a7 = 1'b0;
    for (int l = 0; l < LAYERS; l++)
      for (int a = 0; a < DEPTH; a++)
        exp_q.push_back('{l: 1'(l), a: AW'(a), e: 1'b0});
    exp_done_q.push_back(IB'(2));
    lat_min = 14;
    lat_max = 14;
    @(posedge clk); #1;
    start = 1'b1;
    max_iter = IB'(2);
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (k < 500 && !seen_l1a7) begin
      @(posedge clk);
      k++;
    end
    chk("reached_l1a7", 32'(seen_l1a7), 1);
    @(negedge clk);
    #2;
    hold = 1'b1;
    rst = 1'b0;
    #1;
    chk("arst_rden_LLR", 32'(rden_LLR), 0);
    chk("arst_rden_E", 32'(rden_E), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_rdaddr", 32'(rdaddress), 0);
    chk("arst_rdlayer", 32'(rdlayer), 0);
    chk("arst_iter", 32'(iter_count), 0);
    flush();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    hold = 1'b0;
    decode(1, 14, 14, 1'b1, 1'b0, 1'b0);

`ifdef EARLY_TERM_EN
    pk_iter = 2;
    decode(5, 14, 14, 1'b0, 1'b0, 1'b0);
    pk_iter = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
